// File: rtl/ps2_cmd_sequencer.sv
// PS/2 host command sequencer: sends a command byte and optional argument, then waits for ACK/RESEND/ERROR.
// Optional feature macro PS2_CMD_RETRY_EN enables bounded resends on 0xFE.
module ps2_cmd_sequencer #(
   parameter int ACK_TIMEOUT = 2000000,
   parameter int MAX_RETRIES = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   input  logic [7:0] cmd_byte,
   input  logic       has_arg,
   input  logic [7:0] arg_byte,
   output logic       cmd_ready,
   output logic [7:0] tx_data,
   output logic       tx_w_enable,
   input  logic       tx_idle,
   input  logic       tx_finished,
   input  logic       rx_done_tick,
   input  logic [7:0] rx_data,
   output logic       done,
   output logic [1:0] status
);

   localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   // The increment from LAST lands on ACK_TIMEOUT-1, so done appears ACK_TIMEOUT cycles after tx_finished.
   localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 2);

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_TIMEOUT = 2'b01;
   localparam logic [1:0] ST_RESEND  = 2'b10;
   localparam logic [1:0] ST_DEV_ERR = 2'b11;

   typedef enum logic [2:0] {IDLE, LOAD, WAIT_TX, WAIT_ACK, FINISH} state_t;

   state_t        state, state_nx;
   logic [7:0]    cmd_q, arg_q;
   logic          has_arg_q, idx;
   logic [CW-1:0] cnt;
   logic          latch, adv, cnt_clr, cnt_inc, st_ld;
   logic [1:0]    st_nx;

`ifdef PS2_CMD_RETRY_EN
   localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
   logic [RW-1:0] retry;
   logic          retry_inc;
`endif

   assign cmd_ready = (state == IDLE);
   assign done      = (state == FINISH);
   assign tx_data   = idx ? arg_q : cmd_q;

   always_comb begin
      state_nx    = state;
      tx_w_enable = 1'b0;
      latch       = 1'b0;
      adv         = 1'b0;
      cnt_clr     = 1'b0;
      cnt_inc     = 1'b0;
      st_ld       = 1'b0;
      st_nx       = ST_OK;
`ifdef PS2_CMD_RETRY_EN
      retry_inc   = 1'b0;
`endif
      unique case (state)
         IDLE: if (cmd_valid) begin
            latch    = 1'b1;
            state_nx = LOAD;
         end
         LOAD: if (tx_idle) begin
            tx_w_enable = 1'b1;
            state_nx    = WAIT_TX;
         end
         WAIT_TX: if (tx_finished) begin
            cnt_clr  = 1'b1;
            state_nx = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (rx_done_tick && rx_data == 8'hFA) begin
               if (!idx && has_arg_q) begin
                  adv      = 1'b1;
                  state_nx = LOAD;
               end else begin
                  st_ld    = 1'b1;
                  st_nx    = ST_OK;
                  state_nx = FINISH;
               end
            end else if (rx_done_tick && rx_data == 8'hFE) begin
`ifdef PS2_CMD_RETRY_EN
               if (retry < RW'(MAX_RETRIES)) begin
                  retry_inc = 1'b1;
                  state_nx  = LOAD;
               end else begin
                  st_ld    = 1'b1;
                  st_nx    = ST_RESEND;
                  state_nx = FINISH;
               end
`else
               st_ld    = 1'b1;
               st_nx    = ST_RESEND;
               state_nx = FINISH;
`endif
            end else if (rx_done_tick && rx_data == 8'hFC) begin
               st_ld    = 1'b1;
               st_nx    = ST_DEV_ERR;
               state_nx = FINISH;
            end else begin
               // Unrecognised bytes are treated as silence: the counter keeps running.
               cnt_inc = 1'b1;
               if (cnt == LAST) begin
                  st_ld    = 1'b1;
                  st_nx    = ST_TIMEOUT;
                  state_nx = FINISH;
               end
            end
         end
         FINISH:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cmd_q     <= 8'h00;
         arg_q     <= 8'h00;
         has_arg_q <= 1'b0;
         idx       <= 1'b0;
         cnt       <= '0;
         status    <= ST_OK;
      end else begin
         state <= state_nx;
         if (latch) begin
            cmd_q     <= cmd_byte;
            arg_q     <= arg_byte;
            has_arg_q <= has_arg;
            idx       <= 1'b0;
         end else if (adv) begin
            idx <= 1'b1;
         end
         if (cnt_clr)      cnt <= '0;
         else if (cnt_inc) cnt <= cnt + 1'b1;
         if (st_ld) status <= st_nx;
      end
   end

`ifdef PS2_CMD_RETRY_EN
   // Saturating: increments only while below MAX_RETRIES.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                retry <= '0;
      else if (latch || adv)    retry <= '0;
      else if (retry_inc)       retry <= retry + 1'b1;
   end
`endif

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Bench for ps2_cmd_sequencer: directed and random commands against a device-behaviour reference model.
module tb_ps2_cmd_sequencer;

   localparam int ACK_TIMEOUT = 100;
   localparam int MAX_RETRIES = 3;

   logic       clk = 1'b0;
   logic       reset, cmd_valid, has_arg, tx_idle, tx_finished, rx_done_tick;
   logic [7:0] cmd_byte, arg_byte, rx_data;
   logic       cmd_ready, tx_w_enable, done;
   logic [7:0] tx_data;
   logic [1:0] status;

   int checks = 0;
   int errors = 0;

   // Device responses per command: 0..255 a byte, >=256 an ACK timed onto the timeout cycle, <0 silence.
   int         resp_q[$];
   logic [7:0] exp_tx[$];
   int         exp_status;

   ps2_cmd_sequencer #(.ACK_TIMEOUT(ACK_TIMEOUT), .MAX_RETRIES(MAX_RETRIES)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
      .has_arg(has_arg), .arg_byte(arg_byte), .cmd_ready(cmd_ready), .tx_data(tx_data),
      .tx_w_enable(tx_w_enable), .tx_idle(tx_idle), .tx_finished(tx_finished),
      .rx_done_tick(rx_done_tick), .rx_data(rx_data), .done(done), .status(status)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Protocol-level expectation: which bytes go out and what the final status is.
   task automatic model(input logic [7:0] c, input logic ha, input logic [7:0] a);
      int k = 0, i = 0, rt = 0, r;
      bit fin = 0;
      logic [7:0] b;
      exp_tx.delete();
      exp_tx.push_back(c);
      while (!fin) begin
         r = (k < resp_q.size()) ? resp_q[k] : -1;
         k++;
         b = r[7:0];
         if (r < 0) begin
            exp_status = 1; fin = 1;
         end else if (b == 8'hFA) begin
            if (i == 0 && ha) begin i = 1; rt = 0; exp_tx.push_back(a); end
            else begin exp_status = 0; fin = 1; end
         end else if (b == 8'hFE) begin
`ifdef PS2_CMD_RETRY_EN
            if (rt < MAX_RETRIES) begin rt++; exp_tx.push_back(i == 0 ? c : a); end
            else begin exp_status = 2; fin = 1; end
`else
            exp_status = 2; fin = 1;
`endif
         end else if (b == 8'hFC) begin
            exp_status = 3; fin = 1;
         end
      end
   endtask

   task automatic run_cmd(input string tag, input logic [7:0] c, input logic ha, input logic [7:0] a);
      int n = 0, cyc = 0, tf = 0, dly = 0, phase = 0, r;
      bit fin = 0;
      model(c, ha, a);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_byte = c; has_arg = ha; arg_byte = a; tx_idle = 1'b1;
      #1 chk({tag, "_ready"}, cmd_ready, 1);
      while (!fin && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         tx_finished = 1'b0; rx_done_tick = 1'b0;
         cmd_valid = 1'($urandom_range(0, 1)); cmd_byte = 8'($urandom);
         arg_byte = 8'($urandom); has_arg = 1'($urandom_range(0, 1));
         case (phase)
            0: tx_idle = ($urandom_range(0, 3) != 0);
            1: begin
               tx_idle = 1'b0;
               if ($urandom_range(0, 3) == 0) begin rx_done_tick = 1'b1; rx_data = 8'hFA; end
               if (dly == 0) begin tx_finished = 1'b1; tf = cyc; phase = 2; dly = $urandom_range(0, 5); end
               else dly--;
            end
            2: begin
               tx_idle = 1'b1;
               if (resp_q.size() == 0) phase = 3;
               else if (resp_q[0] < 0) begin void'(resp_q.pop_front()); phase = 3; end
               else if (resp_q[0] >= 256) begin
                  if (cyc - tf == ACK_TIMEOUT - 1) begin
                     r = resp_q.pop_front();
                     rx_done_tick = 1'b1; rx_data = r[7:0]; phase = 0;
                  end
               end else if (dly > 0) dly--;
               else begin
                  r = resp_q.pop_front();
                  rx_done_tick = 1'b1; rx_data = r[7:0];
                  if (r == 8'hFA || r == 8'hFE || r == 8'hFC) phase = 0;
                  else dly = $urandom_range(1, 4);
               end
            end
            default: tx_idle = 1'b1;
         endcase
         #1;
         if (tx_w_enable) begin
            chk({tag, "_txidle"}, tx_idle, 1);
            chk({tag, "_txdata"}, tx_data, (n < exp_tx.size()) ? 32'(exp_tx[n]) : 32'hDEAD);
            n++; phase = 1; dly = $urandom_range(0, 3);
         end else if (phase == 1) begin
            chk({tag, "_txhold"}, tx_data, 32'(exp_tx[n-1]));
         end
         if (done) begin
            chk({tag, "_status"}, status, exp_status);
            chk({tag, "_ntx"}, n, exp_tx.size());
            if (exp_status == 1) chk({tag, "_tolat"}, cyc - tf, ACK_TIMEOUT);
            fin = 1;
         end
      end
      if (!fin) chk({tag, "_nodone"}, 0, 1);
      @(negedge clk);
      cmd_valid = 1'b0; tx_idle = 1'b1; tx_finished = 1'b0; rx_done_tick = 1'b0;
      #1;
      chk({tag, "_donepulse"}, done, 0);
      chk({tag, "_idle"}, cmd_ready, 1);
      resp_q.delete();
   endtask

   initial begin
      int sel, len;
      reset = 1'b1; cmd_valid = 1'b0; cmd_byte = 8'h00; has_arg = 1'b0; arg_byte = 8'h00;
      tx_idle = 1'b1; tx_finished = 1'b0; rx_done_tick = 1'b0; rx_data = 8'h00;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_ready", cmd_ready, 1);
      chk("rst_txen", tx_w_enable, 0);
      chk("rst_done", done, 0);
      chk("rst_status", status, 0);
      chk("rst_txdata", tx_data, 0);
      reset = 1'b0;

      resp_q = '{8'hFA};                      run_cmd("enable", 8'hF4, 1'b0, 8'h00);
      resp_q = '{8'hFA, 8'hFA};               run_cmd("leds", 8'hED, 1'b1, 8'h07);
      resp_q.delete();                        run_cmd("timeout", 8'hFF, 1'b0, 8'h00);
      resp_q = '{8'hFE, 8'hFE, 8'hFE, 8'hFE}; run_cmd("resend", 8'hF3, 1'b0, 8'h00);
      resp_q = '{8'hFA, 8'hFE, 8'hFE, 8'hFA}; run_cmd("argresend", 8'hF3, 1'b1, 8'h2B);
      resp_q = '{8'hAA, 8'hFC};               run_cmd("deverr", 8'hF2, 1'b0, 8'h00);
      resp_q = '{256 + 8'hFA};                run_cmd("racetick", 8'hF5, 1'b0, 8'h00);

      for (int t = 0; t < 40; t++) begin
         len = $urandom_range(1, 6);
         for (int j = 0; j < len; j++) begin
            sel = $urandom_range(0, 99);
            if (sel < 50)      resp_q.push_back(8'hFA);
            else if (sel < 65) resp_q.push_back(8'hFE);
            else if (sel < 72) resp_q.push_back(8'hFC);
            else if (sel < 88) resp_q.push_back(sel[0] ? 8'hAA : 8'h00);
            else if (sel < 92) resp_q.push_back(-1);
            else               resp_q.push_back(8'hFA);
         end
         run_cmd("rand", 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
      end

      // Reset while waiting for the frame to finish abandons the command.
      @(negedge clk);
      cmd_valid = 1'b1; cmd_byte = 8'hF3; has_arg = 1'b1; arg_byte = 8'h0A; tx_idle = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      #1 chk("midrst_txen", tx_w_enable, 1);
      @(negedge clk);
      #1 chk("midrst_busy", cmd_ready, 0);
      reset = 1'b1;
      #1;
      chk("midrst_ready", cmd_ready, 1);
      chk("midrst_txen0", tx_w_enable, 0);
      chk("midrst_done", done, 0);
      chk("midrst_txdata", tx_data, 0);
      chk("midrst_status", status, 0);
      @(negedge clk);
      reset = 1'b0; tx_idle = 1'b0; tx_finished = 1'b1;
      @(negedge clk);
      tx_finished = 1'b0; rx_done_tick = 1'b1; rx_data = 8'hFA;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("postrst_nodone", done, 0);
         chk("postrst_ready", cmd_ready, 1);
         @(negedge clk);
         rx_done_tick = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ps2_cmd_sequencer.md
PS2_CMD_SEQUENCER -- requirements
Module: ps2_cmd_sequencer

Interface
REQ-001 Parameter ACK_TIMEOUT, 2000000, clk cycles (20 ms at 100 MHz) allowed from tx_finished to a device response byte.
REQ-002 Parameter MAX_RETRIES, 3, resends allowed per byte on 0xFE response.
REQ-003 clk  in  1  system clock, 100 MHz.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_byte  in  8  command opcode (e.g. 0xED set LEDs).
REQ-007 has_arg  in  1  command carries one argument byte.
REQ-008 arg_byte  in  8  argument byte.
REQ-009 cmd_ready  out  1  sequencer can accept a command.
REQ-010 tx_data  out  8  byte to PS/2 transmitter data input.
REQ-011 tx_w_enable  out  1  one-cycle transmit start to transmitter.
REQ-012 tx_idle  in  1  transmitter idle.
REQ-013 tx_finished  in  1  one-cycle pulse, transmitter frame complete.
REQ-014 rx_done_tick  in  1  one-cycle pulse, receiver has a byte.
REQ-015 rx_data  in  8  received byte, valid with rx_done_tick.
REQ-016 done  out  1  one-cycle pulse, command finished.
REQ-017 status  out  2  valid with done: 00 OK, 01 TIMEOUT, 10 RESEND_EXHAUSTED, 11 DEVICE_ERROR.

Function
REQ-018 States SHALL be IDLE, LOAD, WAIT_TX, WAIT_ACK, FINISH.
REQ-019 cmd_ready SHALL be 1 only in IDLE; handshake occurs on cmd_valid & cmd_ready.
REQ-020 On handshake: latch cmd_byte, arg_byte, has_arg; byte index := 0; retry count := 0; go to LOAD next cycle.
REQ-021 cmd_valid outside IDLE SHALL be ignored; latched values SHALL not change until next handshake.
REQ-022 tx_data SHALL present latched cmd_byte when index = 0, latched arg_byte when index = 1, stable from LOAD entry until leaving WAIT_TX.
REQ-023 LOAD: wait for tx_idle = 1; in that cycle assert tx_w_enable for exactly one cycle and go to WAIT_TX.
REQ-024 WAIT_TX: on tx_finished, clear timeout counter to 0 and go to WAIT_ACK.
REQ-025 WAIT_ACK: timeout counter increments each cycle without rx_done_tick.
REQ-026 rx_done_tick with rx_data 0xFA: if index = 0 and has_arg, index := 1, retry := 0, go LOAD; else status 00, go FINISH.
REQ-027 rx_done_tick with 0xFE: resend handling per REQ-036/037.
REQ-028 rx_done_tick with 0xFC: status 11, go FINISH.
REQ-029 rx_done_tick with any other value: ignored, counter continues.
REQ-030 Counter reaching ACK_TIMEOUT-1 without rx_done_tick: status 01, go FINISH.
REQ-031 rx_done_tick and timeout in the same cycle: received byte SHALL take priority.
REQ-032 rx_done_tick outside WAIT_ACK SHALL be ignored.
REQ-033 FINISH: done = 1 for one cycle with status; return to IDLE next cycle; status holds until next done.
REQ-034 Timeout counter width SHALL be $clog2(ACK_TIMEOUT); retry counter SHALL saturate, never wrap.

Reset
REQ-035 Reset SHALL force IDLE, cmd_ready 1, tx_w_enable 0, done 0, status 00, tx_data 0x00, all counters 0; mid-command reset abandons command without done.

Configuration
REQ-036 With PS2_CMD_RETRY_EN defined: 0xFE with retry < MAX_RETRIES SHALL increment retry and return to LOAD resending the same byte; with retry = MAX_RETRIES SHALL give status 10, FINISH.
REQ-037 Without PS2_CMD_RETRY_EN: 0xFE SHALL immediately give status 10, FINISH; no retry counter is built.

Verification
REQ-038 cmd 0xF4, has_arg 0, tx_idle 1 -> tx_w_enable pulse with tx_data 0xF4; tx_finished; rx 0xFA -> done, status 00.
REQ-039 cmd 0xED, arg 0x07 -> two transmit pulses, tx_data 0xED then 0x07, each followed by rx 0xFA -> single done, status 00.
REQ-040 cmd 0xFF, ACK_TIMEOUT = 100, no rx after tx_finished -> done exactly 100 cycles after tx_finished, status 01.
REQ-041 Retry enabled, rx 0xFE four times -> four transmit pulses of same byte, then done, status 10; disabled -> one pulse, status 10.
REQ-042 rx 0xAA then 0xFC in WAIT_ACK -> 0xAA ignored, done status 11; rx_done_tick with 0xFA on timeout cycle -> status 00.
REQ-043 Reset asserted in WAIT_TX -> next cycle IDLE, cmd_ready 1, no done pulse, tx_w_enable 0.
